// File: rtl/ccd_capture_pkg.sv
// Purpose: shared types and widths for the CMOS sensor capture front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: capture FSM state type, pixel/counter/frame-count widths.
package ccd_capture_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_CAPTURE
    } cap_state_t;

    localparam int DATA_W  = 12;
    localparam int CNT_W   = 16;
    localparam int FRAME_W = 32;

endpackage

// File: rtl/fval_edge_det.sv
// Purpose: registers the sensor frame-valid strobe and flags its edges.
// Latency: d_FVAL is iFVAL delayed 1 cycle; edges are combinational from d_FVAL/d_FVAL_p.
// Backpressure: none, follows the sensor every cycle.
// Ports:
//   iCLK, iRST   pixel clock, async active-high reset
//   iFVAL        raw sensor frame valid
//   d_FVAL       registered frame valid
//   fval_rise    d_FVAL first high cycle of a frame
//   fval_fall    d_FVAL first low cycle after a frame
module fval_edge_det (
    input  logic iCLK,
    input  logic iRST,
    input  logic iFVAL,
    output logic d_FVAL,
    output logic fval_rise,
    output logic fval_fall
);

    logic d_FVAL_p;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            d_FVAL   <= 1'b0;
            d_FVAL_p <= 1'b0;
        end else begin
            d_FVAL   <= iFVAL;
            d_FVAL_p <= d_FVAL;
        end
    end

    assign fval_rise = d_FVAL & ~d_FVAL_p;
    assign fval_fall = ~d_FVAL & d_FVAL_p;

endmodule

// File: rtl/ccd_capture.sv
// Purpose: sensor capture stage; frame-aligned start/stop, data-valid gating, X/Y and frame counters.
// Latency: 2 cycles from iDATA/iLVAL to oDATA/oDVAL.
// Backpressure: none; oDVAL may be high every cycle.
// Ports:
//   iCLK, iRST            pixel clock, async active-high reset
//   iDATA, iFVAL, iLVAL   raw sensor pixel and strobes
//   iSTART, iEND          single-cycle arm / stop-request pulses
//   oDATA, oDVAL          registered pixel and its captured-pixel qualifier
//   oX_Cont, oY_Cont      coordinates of the pixel on oDATA
//   oFrame_Cont           number of completed captured frames
// Build option: CCD_CAPTURE_TEST_PATTERN_EN replaces pixel data with {X[5:0],Y[5:0]}.
module ccd_capture
    import ccd_capture_pkg::*;
#(
    parameter int COLUMN_WIDTH = 1280
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iEND,
    output logic [DATA_W-1:0]  oDATA,
    output logic               oDVAL,
    output logic [CNT_W-1:0]   oX_Cont,
    output logic [CNT_W-1:0]   oY_Cont,
    output logic [FRAME_W-1:0] oFrame_Cont
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(COLUMN_WIDTH - 1);

    logic       d_LVAL;
    logic       d_FVAL;
    logic       fval_rise;
    logic       fval_fall;
    cap_state_t state;
    cap_state_t stateNext;
    logic       stop_req;
    logic       stopReqNext;
    logic       capPix;
    logic [CNT_W-1:0] xCnt;
    logic [CNT_W-1:0] yCnt;

    fval_edge_det uEdge (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iFVAL     (iFVAL),
        .d_FVAL    (d_FVAL),
        .fval_rise (fval_rise),
        .fval_fall (fval_fall)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            d_LVAL <= 1'b0;
        end else begin
            d_LVAL <= iLVAL;
        end
    end

    // State machine ------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= CAP_IDLE;
            stop_req <= 1'b0;
        end else begin
            state    <= stateNext;
            stop_req <= stopReqNext;
        end
    end

    always_comb begin
        stateNext   = state;
        stopReqNext = stop_req;
        case (state)
            CAP_IDLE: begin
                // iEND in the same cycle cancels the arm request.
                if (iSTART && !iEND) stateNext = CAP_ARMED;
            end
            CAP_ARMED: begin
                // Only a fresh FVAL rise starts capture, so arming mid-frame
                // waits out the rest of the current frame.
                if (iEND)           stateNext = CAP_IDLE;
                else if (fval_rise) stateNext = CAP_CAPTURE;
            end
            CAP_CAPTURE: begin
                // Stop is deferred to the frame's end so no partial frame leaves.
                if (fval_fall && (stop_req || iEND)) begin
                    stateNext   = CAP_IDLE;
                    stopReqNext = 1'b0;
                end else if (iEND) begin
                    stopReqNext = 1'b1;
                end
            end
            default: begin
                stateNext   = CAP_IDLE;
                stopReqNext = 1'b0;
            end
        endcase
    end

    assign capPix = (state == CAP_CAPTURE) & d_FVAL & d_LVAL;

    // Coordinate counters: xCnt/yCnt hold the coordinates the next captured
    // pixel will receive; they are copied to the outputs alongside the pixel.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (!d_FVAL) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (capPix) begin
            if (xCnt == X_LAST) begin
                xCnt <= '0;
                yCnt <= yCnt + 1'b1;
            end else begin
                xCnt <= xCnt + 1'b1;
            end
        end
    end

    // Output stage -------------------------------------------------------
`ifndef CCD_CAPTURE_TEST_PATTERN_EN
    logic [DATA_W-1:0] d_DATA;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            d_DATA <= '0;
        end else begin
            d_DATA <= iDATA;
        end
    end
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
        end else begin
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
            oDATA <= {xCnt[5:0], yCnt[5:0]};
`else
            oDATA <= d_DATA;
`endif
            oDVAL <= capPix;
            if (!d_FVAL) begin
                oX_Cont <= '0;
                oY_Cont <= '0;
            end else if (capPix) begin
                oX_Cont <= xCnt;
                oY_Cont <= yCnt;
            end
            // Counts the final frame before a stop too: state is still
            // CAPTURE in the cycle fval_fall is seen.
            if ((state == CAP_CAPTURE) && fval_fall) begin
                oFrame_Cont <= oFrame_Cont + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccd_capture.sv
// Purpose: self-checking bench for ccd_capture with a frame-level reference model.
// Latency: expects pixels 2 cycles after drive; frame count 2 cycles after FVAL falls.
// Backpressure: none; scoreboard pops one expected pixel per oDVAL.
module tb_ccd_capture;

    localparam int CW = 1280;

    logic        iCLK;
    logic        iRST;
    logic [11:0] iDATA;
    logic        iFVAL;
    logic        iLVAL;
    logic        iSTART;
    logic        iEND;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;

    ccd_capture #(.COLUMN_WIDTH(CW)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iDATA       (iDATA),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iSTART      (iSTART),
        .iEND        (iEND),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [11:0] d;
        logic [15:0] x;
        logic [15:0] y;
    } pix_t;

    int total = 0;
    int bad   = 0;

    // Reference model: capture mode 0=off, 1=armed, 2=running.
    pix_t        expq[$];
    int          mMode    = 0;
    bit          mStop    = 0;
    bit          frameCap = 0;
    int          mPix     = 0;
    int unsigned mCount   = 0;

    int          dvalCnt  = 0;
    logic [15:0] lastX    = '0;
    logic [15:0] lastY    = '0;
    bit          patSeen  = 0;
    logic [11:0] patData  = '0;

    // Scoreboard: every captured pixel must match the model's next pixel.
    always @(negedge iCLK) begin
        if (!iRST && oDVAL) begin
            pix_t e;
            dvalCnt++;
            lastX = oX_Cont;
            lastY = oY_Cont;
            if (oX_Cont == 16'd65 && oY_Cont == 16'd3) begin
                patSeen = 1;
                patData = oDATA;
            end
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dval got d=%h x=%0d y=%0d want no pixel", oDATA, oX_Cont, oY_Cont);
            end else begin
                e = expq.pop_front();
                if ({oDATA, oX_Cont, oY_Cont} !== {e.d, e.x, e.y}) begin
                    bad++;
                    $display("FAIL pixel got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                             oDATA, oX_Cont, oY_Cont, e.d, e.x, e.y);
                end
            end
        end
    end

    task automatic cyc(input bit fv, input bit lv, input bit st, input bit en);
        pix_t p;
        @(posedge iCLK);
        #1;
        iFVAL  = fv;
        iLVAL  = lv;
        iSTART = st;
        iEND   = en;
        iDATA  = 12'($urandom);
        if (en) begin
            if (mMode == 1)      mMode = 0;
            else if (mMode == 2) mStop = 1;
        end else if (st && mMode == 0) begin
            mMode = 1;
        end
        if (fv && lv && frameCap) begin
            p.x = 16'(mPix % CW);
            p.y = 16'((mPix / CW) % 65536);
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
            p.d = {p.x[5:0], p.y[5:0]};
`else
            p.d = iDATA;
`endif
            expq.push_back(p);
            mPix++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic frame_begin();
        if (mMode == 1) mMode = 2;
        frameCap = (mMode == 2);
        mPix     = 0;
    endtask

    task automatic frame_end();
        if (mMode == 2) begin
            mCount++;
            if (mStop) begin
                mMode = 0;
                mStop = 0;
            end
        end
        frameCap = 0;
    endtask

    // One frame: FVAL setup, lines with 4-cycle blanking, then FVAL falls.
    // An optional start/end pulse goes in the blanking after line evLine.
    task automatic drive_frame(input int lines, input int len, input int evLine,
                               input bit evSt, input bit evEn);
        frame_begin();
        repeat (3) cyc(1, 0, 0, 0);
        for (int l = 0; l < lines; l++) begin
            repeat (len) cyc(1, 1, 0, 0);
            cyc(1, 0, (l == evLine) && evSt, (l == evLine) && evEn);
            repeat (3) cyc(1, 0, 0, 0);
        end
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        frame_end();
    endtask

    task automatic test_reset();
        iRST = 1; iFVAL = 0; iLVAL = 0; iSTART = 0; iEND = 0; iDATA = '0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        total++;
        if ({oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got d=%h v=%b x=%0d y=%0d f=%0d want all 0",
                     oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont);
        end
        iRST = 0;
        idle(4);
    endtask

    task automatic test_arm_before_frame();
        int d0;
        d0 = dvalCnt;
        cyc(0, 0, 1, 0);
        idle(4);
        drive_frame(2, 1280, -1, 0, 0);
        @(negedge iCLK);
        @(negedge iCLK);
        total++;
        if (oFrame_Cont !== 32'd0) begin
            bad++;
            $display("FAIL frame_cnt_early got %0d want 0", oFrame_Cont);
        end
        @(negedge iCLK);
        total++;
        if (oFrame_Cont !== 32'd1) begin
            bad++;
            $display("FAIL frame_cnt_2cyc got %0d want 1", oFrame_Cont);
        end
        idle(4);
        total++;
        if (dvalCnt - d0 !== 2560) begin
            bad++;
            $display("FAIL arm_dval_count got %0d want 2560", dvalCnt - d0);
        end
        total++;
        if ({lastX, lastY} !== {16'd1279, 16'd1}) begin
            bad++;
            $display("FAIL arm_last_pixel got (%0d,%0d) want (1279,1)", lastX, lastY);
        end
    endtask

    task automatic test_arm_mid_frame();
        int d0;
        d0 = dvalCnt;
        cyc(0, 0, 0, 1);            // stop whatever is running after this frame
        idle(4);
        drive_frame(2, 1280, -1, 0, 0);
        idle(4);
        d0 = dvalCnt;
        drive_frame(2, 1280, 0, 1, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 0) begin
            bad++;
            $display("FAIL midarm_same_frame got %0d dval want 0", dvalCnt - d0);
        end
        d0 = dvalCnt;
        drive_frame(2, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 2560) begin
            bad++;
            $display("FAIL midarm_next_frame got %0d dval want 2560", dvalCnt - d0);
        end
        total++;
        if (oFrame_Cont !== 32'd3) begin
            bad++;
            $display("FAIL midarm_frame_cnt got %0d want 3", oFrame_Cont);
        end
    endtask

    task automatic test_stop_mid_frame();
        int d0;
        d0 = dvalCnt;
        drive_frame(3, 1280, 1, 0, 1);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 3840) begin
            bad++;
            $display("FAIL stop_frame_completes got %0d dval want 3840", dvalCnt - d0);
        end
        total++;
        if (oFrame_Cont !== 32'd4) begin
            bad++;
            $display("FAIL stop_frame_cnt got %0d want 4", oFrame_Cont);
        end
        d0 = dvalCnt;
        drive_frame(2, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 0 || oFrame_Cont !== 32'd4) begin
            bad++;
            $display("FAIL stop_after got dval=%0d f=%0d want dval=0 f=4", dvalCnt - d0, oFrame_Cont);
        end
    endtask

    task automatic test_simultaneous();
        int d0;
        d0 = dvalCnt;
        cyc(0, 0, 1, 1);
        idle(4);
        drive_frame(2, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 0 || oFrame_Cont !== 32'd4) begin
            bad++;
            $display("FAIL simultaneous got dval=%0d f=%0d want dval=0 f=4", dvalCnt - d0, oFrame_Cont);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        cyc(0, 0, 1, 0);
        idle(4);
        frame_begin();
        repeat (3) cyc(1, 0, 0, 0);
        for (int r = 0; r < 20; r++) begin
            repeat (1280) cyc(1, 1, 0, 0);
            repeat (4) cyc(1, 0, 0, 0);
        end
        repeat (501) cyc(1, 1, 0, 0);
        @(negedge iCLK);
        @(negedge iCLK);
        @(negedge iCLK);
        total++;
        if ({oDVAL, oX_Cont, oY_Cont} !== {1'b1, 16'd500, 16'd20}) begin
            bad++;
            $display("FAIL pre_reset_pixel got v=%b (%0d,%0d) want v=1 (500,20)", oDVAL, oX_Cont, oY_Cont);
        end
        #1;
        iRST = 1;
        #1;
        total++;
        if ({oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont} !== '0) begin
            bad++;
            $display("FAIL async_reset got d=%h v=%b x=%0d y=%0d f=%0d want all 0",
                     oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont);
        end
        iFVAL = 0; iLVAL = 0;
        mMode = 0; mStop = 0; frameCap = 0; mCount = 0;
        expq.delete();
        @(negedge iCLK);
        iRST = 0;
        idle(4);
        d0 = dvalCnt;
        drive_frame(2, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 0 || oFrame_Cont !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_capture got dval=%0d f=%0d want dval=0 f=0", dvalCnt - d0, oFrame_Cont);
        end
        cyc(0, 0, 1, 0);
        idle(4);
        d0 = dvalCnt;
        drive_frame(2, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (dvalCnt - d0 !== 2560 || oFrame_Cont !== 32'd1) begin
            bad++;
            $display("FAIL reset_rearm got dval=%0d f=%0d want dval=2560 f=1", dvalCnt - d0, oFrame_Cont);
        end
    endtask

`ifdef CCD_CAPTURE_TEST_PATTERN_EN
    task automatic test_pattern();
        patSeen = 0;
        if (mMode == 0) cyc(0, 0, 1, 0);
        idle(4);
        drive_frame(4, 1280, -1, 0, 0);
        idle(6);
        total++;
        if (!patSeen || patData !== 12'h043) begin
            bad++;
            $display("FAIL pattern_65_3 got seen=%0d d=%h want seen=1 d=043", patSeen, patData);
        end
    endtask
`endif

    task automatic test_random();
        int d0;
        int lines;
        int len;
        int want;
        int unsigned wantCnt;
        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 3))
                1: cyc(0, 0, 1, 0);
                2: cyc(0, 0, 0, 1);
                3: cyc(0, 0, 1, 1);
                default: cyc(0, 0, 0, 0);
            endcase
            idle(4);
            lines = $urandom_range(1, 3);
            len   = $urandom_range(8, 700);
            want  = (mMode != 0) ? lines * len : 0;
            d0    = dvalCnt;
            drive_frame(lines, len, $urandom_range(0, lines), 1'($urandom), 1'($urandom));
            idle(6);
            wantCnt = mCount;
            total++;
            if (dvalCnt - d0 !== want || oFrame_Cont !== wantCnt) begin
                bad++;
                $display("FAIL random_frame%0d got dval=%0d f=%0d want dval=%0d f=%0d",
                         f, dvalCnt - d0, oFrame_Cont, want, wantCnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm_before_frame();
        test_arm_mid_frame();
        test_stop_mid_frame();
        test_simultaneous();
        test_reset_mid_frame();
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
        test_pattern();
`endif
        test_random();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL leftover_pixels got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccd_capture.md
# ccd_capture

Front-end capture stage between the CMOS sensor pins and the Bayer demosaic stage. It registers the sensor's raw 12-bit pixel stream and its frame-valid and line-valid strobes. It runs a start/stop capture state machine that only begins and ends on whole-frame boundaries. It produces a data-valid strobe, per-pixel X/Y coordinates and a completed-frame count, which is exactly what the demosaic stage consumes.

## Interface
- `COLUMN_WIDTH`, default 1280: active pixels per line. X wraps to 0 after `COLUMN_WIDTH-1`.
- `iCLK` in, 1 bit: sensor pixel clock. Single clock domain.
- `iRST` in, 1 bit: reset, asynchronous, active-high.
- `iDATA` in, 12 bits: raw Bayer pixel from the sensor.
- `iFVAL` in, 1 bit: sensor frame valid.
- `iLVAL` in, 1 bit: sensor line valid.
- `iSTART` in, 1 bit: single-cycle pulse that arms capture.
- `iEND` in, 1 bit: single-cycle pulse that requests a stop.
- `oDATA` out, 12 bits: registered pixel.
- `oDVAL` out, 1 bit: `oDATA` is a captured active pixel.
- `oX_Cont` out, 16 bits: column of the pixel on `oDATA`.
- `oY_Cont` out, 16 bits: row of the pixel on `oDATA`.
- `oFrame_Cont` out, 32 bits: number of completed captured frames.

## Operation
- **Stage 1:** registers `iDATA`, `iFVAL` and `iLVAL` into `d_DATA`, `d_FVAL` and `d_LVAL`. It also keeps `d_FVAL_p` (`d_FVAL` delayed one cycle).
  - `fval_rise = d_FVAL & ~d_FVAL_p`
  - `fval_fall = ~d_FVAL & d_FVAL_p`
- **State machine states:** IDLE, ARMED, CAPTURE.
  - IDLE: `iSTART` moves to ARMED.
  - ARMED: `iEND` returns to IDLE. `fval_rise` moves to CAPTURE.
    - If FVAL is already high when armed, capture waits for it to go low and then rise again. Capture never starts mid-frame.
  - CAPTURE: `iEND` sets the `stop_req` flag. When `fval_fall` occurs with `stop_req` set (or `iEND` in the same cycle), the state moves to IDLE and `stop_req` is cleared.
  - `iSTART` is ignored outside IDLE.
  - `iSTART` and `iEND` in the same cycle: `iEND` wins. IDLE stays IDLE; ARMED goes to IDLE.
- **Gating:**
  - `oDVAL <= (state==CAPTURE) & d_FVAL & d_LVAL`
  - `oDATA <= d_DATA` every cycle, ungated.
- **Counters:**
  - Advance only on cycles where the registered `oDVAL` condition is true.
  - X increments. At `COLUMN_WIDTH-1`, X goes to 0 and Y increments.
  - Y is 16 bits and wraps naturally at 65535 to 0.
  - On `fval_fall`, or whenever `d_FVAL` is low, X and Y are forced to 0.
  - `oX_Cont`/`oY_Cont` always equal the coordinates of the pixel currently on `oDATA` when `oDVAL` is 1. The first captured pixel of a frame is (0,0).
- **Frame counter:** `oFrame_Cont` increments on each `fval_fall` seen in CAPTURE, including the final frame before a stop. It wraps modulo 2^32.
- **Reset:**
  - All outputs and registers go to 0 and the state goes to IDLE.
  - Reset mid-frame abandons the frame. A new `iSTART` is required.
  - `oFrame_Cont` is cleared.

## Timing
- Latency is 2 cycles from `iDATA`/`iLVAL` to `oDATA`/`oDVAL`.
- State is updated at the clock edge after `fval_rise` is seen in stage 1. A pixel with LVAL high in the same input cycle as FVAL's first high cycle is dropped. Sensor timing guarantees at least 2 cycles of FVAL-to-LVAL setup, so this is acceptable.
- In the stop cycle, `oDVAL` is already 0 because `d_FVAL` is low. No partial frame is ever emitted.
- `oDVAL` can be high every cycle. There is no backpressure.

## Configuration
- `CCD_CAPTURE_TEST_PATTERN_EN`
  - Defined: `oDATA <= {X[5:0], Y[5:0]}`, using the coordinates assigned to that pixel. Sensor data is ignored, while timing, gating and counters are unchanged.
  - Undefined: `oDATA <= d_DATA`, and the pattern logic is absent.

## Structure
- Package `ccd_capture_pkg` holds:
  - `typedef enum logic [1:0] {CAP_IDLE, CAP_ARMED, CAP_CAPTURE} cap_state_t`
  - `localparam DATA_W = 12`
  - `localparam CNT_W = 16`
  - `localparam FRAME_W = 32`
- One sub-module, `fval_edge_det`: it registers FVAL and outputs `d_FVAL`, `fval_rise` and `fval_fall`.
- The state machine, gating and counters stay in `ccd_capture`.

## Test plan
- **Arm before frame:** `iSTART`, then FVAL high, then 2 lines of LVAL with 1280 pixels each, with `COLUMN_WIDTH`=1280. Expect 2560 `oDVAL` cycles. The last pixel is (1279,1). `oFrame_Cont` goes to 1 two cycles after FVAL falls.
- **Arm mid-frame:** `iSTART` while FVAL is high. Expect zero `oDVAL` for the rest of that frame, and full capture starting at (0,0) in the next frame.
- **Stop mid-frame:** `iEND` during row 100 of frame 3. Expect frame 3 to complete, `oFrame_Cont`=3, state IDLE, and zero `oDVAL` in frame 4.
- **Simultaneous:** `iSTART` and `iEND` in the same cycle from IDLE. Expect the state to stay IDLE and no `oDVAL` in the next frame.
- **Reset mid-frame:** assert `iRST` at pixel (500,20). Expect all outputs 0 immediately and no capture until a new `iSTART`.
- **Test pattern** (`CCD_CAPTURE_TEST_PATTERN_EN` defined): the pixel at (65,3) outputs 12'h043, regardless of `iDATA`.
